// File: rtl/fetch_ifid_if.sv
// -----------------------------------------------------------------------------
// fetch_ifid_if : instruction-memory fetch bus between the IF stage and imem.
//
//   imem_addr  : fetch address, driven by the fetch stage (equals current PC)
//   imem_data  : instruction halfword at imem_addr, driven by memory
//   imem_valid : imem_data valid this cycle, driven by memory
//
// Modports:
//   master : fetch-stage side (drives imem_addr)
//   slave  : memory side (drives imem_data / imem_valid)
// -----------------------------------------------------------------------------
interface fetch_ifid_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;

  modport master (
    output imem_addr,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/fetch_ifid.sv
// -----------------------------------------------------------------------------
// fetch_ifid : instruction fetch stage with the IF/ID pipeline register.
//
// Holds the PC, issues fetches on the imem bus, and latches fetched
// instructions together with their PC+2 into the IF/ID register. Supports
// hazard stalls (independent PC / IF/ID write enables), branch redirect with
// IF/ID flush, and a HALTED state entered when HLT (opcode 4'hF) is loaded.
//
// Optional build macro:
//   IMEM_WAIT_EN : when defined, imem_valid is honoured and a WAIT state
//                  holds the PC while memory is busy. When undefined,
//                  imem_valid is ignored and fetch_busy is tied low.
//
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   PC_write_en    : 1 = PC may update, 0 = hold PC
//   IFID_write_en  : 1 = IF/ID may load, 0 = hold IF/ID (also gates flush)
//   Branch_taken   : redirect to Branch_target and flush IF/ID
//   Branch_target  : redirect address (bit 0 forced to 0)
//   imem           : fetch bus (master modport): imem_addr/imem_data/imem_valid
//   IFID_instr     : latched instruction
//   IFID_pc_plus2  : PC+2 of the latched instruction
//   IFID_valid     : 1 = real instruction, 0 = bubble
//   IFID_opcode/RegisterRd/RegisterRs/RegisterRt : IFID_instr nibbles
//   halted         : HLT latched, fetch frozen
//   fetch_busy     : fetch waiting on imem_valid
// -----------------------------------------------------------------------------
module fetch_ifid (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                PC_write_en,
  input  logic                IFID_write_en,
  input  logic                Branch_taken,
  input  logic [15:0]         Branch_target,
  fetch_ifid_if.master        imem,
  output logic [15:0]         IFID_instr,
  output logic [15:0]         IFID_pc_plus2,
  output logic                IFID_valid,
  output logic [3:0]          IFID_opcode,
  output logic [3:0]          IFID_RegisterRd,
  output logic [3:0]          IFID_RegisterRs,
  output logic [3:0]          IFID_RegisterRt,
  output logic                halted,
  output logic                fetch_busy
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pp2_q, pp2_d;
  logic        valid_q, valid_d;

  logic [15:0] pc_plus2;
  logic        flush;
  logic        mem_ok;
  logic        fetch_is_hlt;

  // Fetch address is the PC in every state.
  assign imem.imem_addr = pc_q;

  // 16-bit add wraps naturally (FFFE + 2 = 0000).
  assign pc_plus2     = pc_q + 16'd2;
  // A branch is only honoured when the IF/ID register can be flushed.
  assign flush        = Branch_taken && IFID_write_en;
  assign fetch_is_hlt = (imem.imem_data[15:12] == OP_HLT);

`ifdef IMEM_WAIT_EN
  assign mem_ok     = imem.imem_valid;
  assign fetch_busy = (state_q == WAIT);
`else
  // Memory is single-cycle: imem_valid is intentionally ignored.
  logic unused_imem_valid;
  assign unused_imem_valid = imem.imem_valid;
  assign mem_ok            = 1'b1;
  assign fetch_busy        = 1'b0;
`endif

  assign halted = (state_q == HALTED);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      pp2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp2_q   <= pp2_d;
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath: flush > stall > memory wait > normal advance.
  // Stalls are expressed by the enables gating individual register loads.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp2_d   = pp2_q;
    valid_d = valid_q;

    if (flush) begin
      pc_d    = {Branch_target[15:1], 1'b0};
      instr_d = '0;
      valid_d = 1'b0;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        HALTED: begin
          // Frozen until a flush or reset.
        end

        FETCH, WAIT: begin
          if (mem_ok) begin
            // PC never steps past a HLT, so a stalled HLT is refetched later.
            if (PC_write_en && !fetch_is_hlt) begin
              pc_d = pc_plus2;
            end
            if (IFID_write_en) begin
              instr_d = imem.imem_data;
              pp2_d   = pc_plus2;
              valid_d = 1'b1;
              state_d = fetch_is_hlt ? HALTED : FETCH;
            end else begin
              state_d = FETCH;
            end
          end else begin
            // No data yet: hold PC and feed a bubble downstream.
            state_d = WAIT;
            if (IFID_write_en) begin
              instr_d = '0;
              valid_d = 1'b0;
            end
          end
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  assign IFID_instr      = instr_q;
  assign IFID_pc_plus2   = pp2_q;
  assign IFID_valid      = valid_q;
  assign IFID_opcode     = instr_q[15:12];
  assign IFID_RegisterRd = instr_q[11:8];
  assign IFID_RegisterRs = instr_q[7:4];
  assign IFID_RegisterRt = instr_q[3:0];

endmodule

// File: doc/fetch_ifid.md
FETCH_IFID -- requirements
Module: fetch_ifid

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: PC_write_en  input  1  1 = PC may update; 0 = hold PC (hazard stall).
REQ-004 SHALL have port: IFID_write_en  input  1  1 = IF/ID register may load; 0 = hold IF/ID.
REQ-005 SHALL have port: Branch_taken  input  1  ID-stage B/BR resolved taken; redirect and flush.
REQ-006 SHALL have port: Branch_target  input  16  redirect PC, halfword-aligned byte address.
REQ-007 SHALL have port: imem_addr  output  16  instruction fetch address, equal to current PC.
REQ-008 SHALL have port: imem_data  input  16  instruction word at imem_addr.
REQ-009 SHALL have port: imem_valid  input  1  imem_data valid this cycle.
REQ-010 SHALL have port: IFID_instr  output  16  latched instruction.
REQ-011 SHALL have port: IFID_pc_plus2  output  16  PC+2 of latched instruction.
REQ-012 SHALL have port: IFID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-013 SHALL have ports: IFID_opcode, IFID_RegisterRd, IFID_RegisterRs, IFID_RegisterRt  output  4 each  IFID_instr[15:12], [11:8], [7:4], [3:0].
REQ-014 SHALL have port: halted  output  1  HLT (opcode 4'b1111) latched; fetch frozen.
REQ-015 SHALL have port: fetch_busy  output  1  fetch waiting on imem_valid.

Function
REQ-016 SHALL implement states FETCH, WAIT, HALTED; imem_addr SHALL equal PC combinationally in all states.
REQ-017 Per-cycle priority SHALL be: reset > flush > stall > memory wait > normal advance.
REQ-018 Flush (Branch_taken=1 and IFID_write_en=1): PC <= Branch_target, IFID_valid <= 0, IFID_instr <= 16'h0000, state <= FETCH, from any state including HALTED and WAIT.
REQ-019 Branch_taken SHALL be ignored while IFID_write_en=0.
REQ-020 Stall: PC_write_en=0 holds PC; IFID_write_en=0 holds all IF/ID outputs unchanged; each independent.
REQ-021 Normal advance (FETCH, imem_valid=1, no flush): PC <= PC+2 if PC_write_en; IF/ID <= {imem_data, PC+2}, IFID_valid <= 1 if IFID_write_en; one-cycle latency fetch to IF/ID.
REQ-022 PC+2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000); Branch_target bit 0 SHALL be forced to 0.
REQ-023 Opcode 4'b1111 loaded into IF/ID SHALL move state to HALTED; PC SHALL NOT advance past it.
REQ-024 HALTED: PC frozen, IF/ID holds HLT with IFID_valid=1, halted=1; exits only by flush or reset.
REQ-025 Fetch of HLT coincident with flush: flush wins, HLT discarded, halted stays 0.

Reset
REQ-026 rst_n=0 SHALL asynchronously set PC=16'h0000, IFID_instr=16'h0000, IFID_pc_plus2=16'h0000, IFID_valid=0, halted=0, fetch_busy=0, state=FETCH.
REQ-027 Reset asserted mid-WAIT or mid-stall SHALL abandon the fetch; first fetch after release SHALL be address 16'h0000.

Configuration
REQ-028 Macro IMEM_WAIT_EN SHALL select wait-state support.
REQ-029 With IMEM_WAIT_EN defined: FETCH with imem_valid=0 -> WAIT; in WAIT PC held, fetch_busy=1, IF/ID loads bubble (valid 0, instr 0) when IFID_write_en=1; imem_valid=1 -> normal advance, state FETCH.
REQ-030 Without IMEM_WAIT_EN: imem_valid SHALL be ignored (treated as 1), WAIT unreachable, fetch_busy tied 0.

Verification
REQ-031 Reset release, imem returns 16'h1234,16'h2345 at 0x0000,0x0002 -> cycle 1 IFID_instr=16'h1234, IFID_pc_plus2=16'h0002, valid=1; cycle 2 16'h2345, 16'h0004.
REQ-032 PC_write_en=0, IFID_write_en=0 for 2 cycles at PC 0x0010 -> imem_addr stays 0x0010, IF/ID unchanged; release -> advance resumes.
REQ-033 Branch_taken=1, Branch_target=16'h0041 -> next cycle PC=0x0040, IFID_valid=0, IFID_instr=0; following cycle instr from 0x0040 valid.
REQ-034 Fetch 16'hF000 at 0x0020 -> halted=1, PC=0x0020 held for 10 cycles; then Branch_taken to 0x0100 -> halted=0, fetch from 0x0100.
REQ-035 IMEM_WAIT_EN, imem_valid low 3 cycles at 0x0008 -> fetch_busy=1 three cycles, IFID_valid=0, PC 0x0008; valid high -> instruction latched, PC 0x000A.
REQ-036 PC=16'hFFFE, normal advance -> IFID_pc_plus2=16'h0000, next imem_addr=16'h0000.
